// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and a simple req/ack memory port.
// Handles lane placement, load extension, alignment faults and ack timeouts.
module load_store_unit #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] addr_in,
   input  logic [31:0] store_data_in,
   output logic        req_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] load_data_out,
   output logic        done,
   output logic        misaligned,
   output logic        bus_error
);

   // state  | meaning
   // IDLE   | waiting for a request, req_ready high
   // ACCESS | mem_req held with stable address/lanes until ack or timeout
   // RESP   | one-cycle done pulse after a completed access
   // FAULT  | one-cycle done pulse with misaligned or bus_error
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2,
      S_FAULT  = 2'd3
   } state_t;

   localparam logic [8:0] TO_LIMIT = 9'(ACK_TIMEOUT);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] load_q, load_d;
   logic        buserr_q, buserr_d;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;

   logic        capture;
   logic        aligned;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;
   logic [8:0]  cnt_inc;
   logic        timeout_hit;

   // Lane enables and replicated store data are computed once at accept so
   // the memory port sees them unchanged for the whole access.
   always_comb begin
      aligned   = 1'b0;
      be_new    = 4'b0000;
      wdata_new = store_data_in;
      case (req_size)
         2'b00: begin
            aligned   = 1'b1;
            be_new    = 4'b0001 << addr_in[1:0];
            wdata_new = {4{store_data_in[7:0]}};
         end
         2'b01: begin
            aligned   = ~addr_in[0];
            be_new    = 4'b0011 << addr_in[1:0];
            wdata_new = {2{store_data_in[15:0]}};
         end
         2'b10: begin
            aligned   = (addr_in[1:0] == 2'b00);
            be_new    = 4'b1111;
            wdata_new = store_data_in;
         end
         default: begin
            aligned   = 1'b0;
            be_new    = 4'b0000;
            wdata_new = store_data_in;
         end
      endcase
   end

   always_comb begin
      byte_sel = mem_rdata[7:0];
      half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (addr_q[1:0])
         2'b00:   byte_sel = mem_rdata[7:0];
         2'b01:   byte_sel = mem_rdata[15:8];
         2'b10:   byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      case (size_q)
         2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
         default: load_ext = mem_rdata;
      endcase
   end

   assign cnt_inc     = {1'b0, cnt_q} + 9'd1;
   assign timeout_hit = (cnt_inc == TO_LIMIT);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      load_d   = load_q;
      buserr_d = buserr_q;
      capture  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               capture  = 1'b1;
               cnt_d    = 8'd0;
               buserr_d = 1'b0;
               state_d  = aligned ? S_ACCESS : S_FAULT;
            end
         end
         S_ACCESS: begin
            // An ack arriving on the timeout cycle still completes the access.
            if (mem_ack) begin
               if (!we_q) begin
                  load_d = load_ext;
               end
               state_d = S_RESP;
            end else if (timeout_hit) begin
               buserr_d = 1'b1;
               state_d  = S_FAULT;
            end else begin
               cnt_d = cnt_inc[7:0];
            end
         end
         S_RESP:  state_d = S_IDLE;
         S_FAULT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         load_q   <= 32'd0;
         buserr_q <= 1'b0;
         addr_q   <= 32'd0;
         size_q   <= 2'b00;
         uns_q    <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= 4'b0000;
         wdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         load_q   <= load_d;
         buserr_q <= buserr_d;
         if (capture) begin
            addr_q  <= addr_in;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            we_q    <= req_we;
            be_q    <= be_new;
            wdata_q <= wdata_new;
         end
      end
   end

   assign req_ready     = (state_q == S_IDLE);
   assign mem_req       = (state_q == S_ACCESS);
   assign mem_we        = (state_q == S_ACCESS) & we_q;
   assign mem_be        = (state_q == S_ACCESS) ? be_q : 4'b0000;
   assign mem_addr      = {addr_q[31:2], 2'b00};
   assign mem_wdata     = wdata_q;
   assign load_data_out = load_q;
   assign done          = (state_q == S_RESP) | (state_q == S_FAULT);
   assign misaligned    = (state_q == S_FAULT) & ~buserr_q;
   assign bus_error     = (state_q == S_FAULT) & buserr_q;

endmodule
